// File: rtl/nrisc_idata_pkg.sv
// Shared types and constants for the NRISC instruction-memory boot loader.
package nrisc_idata_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam int         ADDR_W    = 10;
  localparam int         WORD_W    = 16;
  localparam int         CNT_W     = 16;

  typedef enum logic [3:0] {
    S_IDLE,
    S_CNT_HI,
    S_CNT_LO,
    S_DATA_HI,
    S_DATA_LO,
    S_WRITE,
    S_CHECK,
    S_DONE,
    S_ERROR
  } state_t;

  // States that wait on a host byte inside a frame and so can time out.
  function automatic logic is_timed(input state_t s);
    return (s == S_CNT_HI) || (s == S_CNT_LO) || (s == S_DATA_HI) ||
           (s == S_DATA_LO) || (s == S_CHECK);
  endfunction

endpackage

// File: rtl/nrisc_idata_loader_if.sv
// Byte stream in, IDATA programming port and loader status out.
interface nrisc_idata_loader_if;
  import nrisc_idata_pkg::*;

  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              IDATA_PROG_write;
  logic [ADDR_W-1:0] IDATA_PROG_addr;
  logic [WORD_W-1:0] IDATA_PROG_data;
  logic              core_hold;
  logic              done;
  logic              error;
  logic [ADDR_W-1:0] word_cnt;

  modport master (
    input  in_data, in_valid,
    output in_ready, IDATA_PROG_write, IDATA_PROG_addr, IDATA_PROG_data,
           core_hold, done, error, word_cnt
  );

  modport slave (
    output in_data, in_valid,
    input  in_ready, IDATA_PROG_write, IDATA_PROG_addr, IDATA_PROG_data,
           core_hold, done, error, word_cnt
  );

endinterface

// File: rtl/nrisc_idata_timeout.sv
// Inter-byte idle watchdog: reloads on clear, counts down while enabled.
module nrisc_idata_timeout #(
  parameter int unsigned TIMEOUT = 65535
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int            CW     = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(TIMEOUT - 1);

  logic [CW-1:0] count_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_reg <= RELOAD;
    end else if (clear) begin
      count_reg <= RELOAD;
    end else if (enable && (count_reg != '0)) begin
      count_reg <= count_reg - CW'(1);
    end
  end

  // Fires during the TIMEOUT-th consecutive idle cycle after the last reload.
  assign expired = enable && !clear && (count_reg == '0);

endmodule

// File: rtl/nrisc_idata_loader.sv
// Framed byte-stream boot loader driving the NRISC instruction memory programming port.
module nrisc_idata_loader
  import nrisc_idata_pkg::*;
#(
  parameter int unsigned DEPTH         = 256,
  parameter int unsigned TIMEOUT       = 65535,
  parameter bit          HOLD_AT_RESET = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  nrisc_idata_loader_if.master bus
);

  state_t            state_reg, state_next;
  logic              ready_reg;
  logic [7:0]        hi_reg, hi_next;
  logic [7:0]        lo_reg, lo_next;
  logic [CNT_W-1:0]  n_reg, n_next;
  logic [ADDR_W-1:0] word_cnt_reg, word_cnt_next;
  logic [7:0]        xor_reg, xor_next;
  logic              hold_reg, hold_next;
  logic              done_reg, done_next;
  logic              error_reg, error_next;

  logic              in_ready_int;
  logic              xfer;
  logic              timed;
  logic              tmo_expired;
  logic [CNT_W-1:0]  n_full;
  logic [CNT_W-1:0]  wc_inc;

  assign in_ready_int = ready_reg && (state_reg != S_WRITE);
  assign xfer         = bus.in_valid && in_ready_int;
  assign timed        = is_timed(state_reg);

  nrisc_idata_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clear   (xfer || !timed),
    .enable  (timed),
    .expired (tmo_expired)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= S_IDLE;
      ready_reg    <= 1'b0;
      hi_reg       <= 8'h00;
      lo_reg       <= 8'h00;
      n_reg        <= '0;
      word_cnt_reg <= '0;
      xor_reg      <= 8'h00;
      hold_reg     <= HOLD_AT_RESET;
      done_reg     <= 1'b0;
      error_reg    <= 1'b0;
    end else begin
      state_reg    <= state_next;
      ready_reg    <= 1'b1;
      hi_reg       <= hi_next;
      lo_reg       <= lo_next;
      n_reg        <= n_next;
      word_cnt_reg <= word_cnt_next;
      xor_reg      <= xor_next;
      hold_reg     <= hold_next;
      done_reg     <= done_next;
      error_reg    <= error_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    hi_next       = hi_reg;
    lo_next       = lo_reg;
    n_next        = n_reg;
    word_cnt_next = word_cnt_reg;
    xor_next      = xor_reg;
    hold_next     = hold_reg;
    done_next     = done_reg;
    error_next    = error_reg;
    n_full        = {n_reg[CNT_W-1:8], bus.in_data};
    wc_inc        = CNT_W'(word_cnt_reg) + CNT_W'(1);

    case (state_reg)
      S_IDLE, S_DONE, S_ERROR: begin
        if (xfer && (bus.in_data == SYNC_BYTE)) begin
          state_next    = S_CNT_HI;
          hold_next     = 1'b1;
          done_next     = 1'b0;
          error_next    = 1'b0;
          word_cnt_next = '0;
          xor_next      = 8'h00;
        end
      end
      S_CNT_HI: begin
        if (xfer) begin
          n_next     = {bus.in_data, 8'h00};
          state_next = S_CNT_LO;
        end
      end
      S_CNT_LO: begin
        if (xfer) begin
          n_next = n_full;
          if (n_full == '0) begin
            state_next = S_CHECK;
          end else if (n_full > CNT_W'(DEPTH)) begin
            state_next = S_ERROR;
            error_next = 1'b1;
          end else begin
            state_next = S_DATA_HI;
          end
        end
      end
      S_DATA_HI: begin
        if (xfer) begin
          hi_next    = bus.in_data;
          xor_next   = xor_reg ^ bus.in_data;
          state_next = S_DATA_LO;
        end
      end
      S_DATA_LO: begin
        if (xfer) begin
          lo_next    = bus.in_data;
          xor_next   = xor_reg ^ bus.in_data;
          state_next = S_WRITE;
        end
      end
      S_WRITE: begin
        // Address for this strobe is the pre-increment word count.
        word_cnt_next = wc_inc[ADDR_W-1:0];
        state_next    = (wc_inc < n_reg) ? S_DATA_HI : S_CHECK;
      end
      S_CHECK: begin
        if (xfer) begin
          if (bus.in_data == xor_reg) begin
            state_next = S_DONE;
            done_next  = 1'b1;
            hold_next  = 1'b0;
          end else begin
            state_next = S_ERROR;
            error_next = 1'b1;
          end
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase

    if (tmo_expired) begin
      state_next = S_ERROR;
      error_next = 1'b1;
    end
  end

  assign bus.in_ready         = in_ready_int;
  assign bus.IDATA_PROG_write = (state_reg == S_WRITE);
  assign bus.IDATA_PROG_addr  = word_cnt_reg;
  assign bus.IDATA_PROG_data  = {hi_reg, lo_reg};
  assign bus.core_hold        = hold_reg;
  assign bus.done             = done_reg;
  assign bus.error            = error_reg;
  assign bus.word_cnt         = word_cnt_reg;

endmodule

// File: tb/tb_nrisc_idata_loader.sv
// Randomised frame-level bench for nrisc_idata_loader against a queue-based frame model.
module tb_nrisc_idata_loader;

  localparam int DEPTH   = 256;
  localparam int TIMEOUT = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  nrisc_idata_loader_if bus ();

  nrisc_idata_loader #(
    .DEPTH         (DEPTH),
    .TIMEOUT       (TIMEOUT),
    .HOLD_AT_RESET (1'b1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [7:0]  frame_q[$];
  logic [15:0] word_q[$];
  logic [25:0] exp_wr_q[$];
  logic [25:0] got_wr_q[$];
  bit          exp_done;
  bit          exp_error;
  int          exp_wcnt;
  int          multi_cnt = 0;
  bit          prev_wr = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Records every programming strobe; back-to-back high samples mean a stretched strobe.
  always @(negedge clk) begin
    if (bus.IDATA_PROG_write === 1'b1) begin
      got_wr_q.push_back({bus.IDATA_PROG_addr, bus.IDATA_PROG_data});
      if (prev_wr) multi_cnt++;
    end
    prev_wr = (bus.IDATA_PROG_write === 1'b1);
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    int guard = 0;
    repeat (gap) begin
      bus.in_valid = 1'b0;
      bus.in_data  = 8'($urandom);
      @(negedge clk);
    end
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    while (bus.in_ready !== 1'b1 && guard < 8) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 8) check_val("ready_wait", 32'(bus.in_ready), 32'(1));
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic fill_random(input int n);
    word_q.delete();
    for (int i = 0; i < n; i++) word_q.push_back(16'($urandom));
  endtask

  task automatic build_frame(input int n, input bit bad);
    logic [15:0] nn;
    logic [7:0]  chk;
    nn  = 16'(n);
    chk = 8'h00;
    frame_q.delete();
    exp_wr_q.delete();
    frame_q.push_back(8'hA5);
    frame_q.push_back(nn[15:8]);
    frame_q.push_back(nn[7:0]);
    if (n > DEPTH) begin
      exp_done  = 1'b0;
      exp_error = 1'b1;
      exp_wcnt  = 0;
      return;
    end
    for (int i = 0; i < n; i++) begin
      frame_q.push_back(word_q[i][15:8]);
      frame_q.push_back(word_q[i][7:0]);
      chk = chk ^ word_q[i][15:8] ^ word_q[i][7:0];
      exp_wr_q.push_back({10'(i), word_q[i]});
    end
    frame_q.push_back(bad ? (chk ^ 8'h01) : chk);
    exp_done  = !bad;
    exp_error = bad;
    exp_wcnt  = n;
  endtask

  task automatic run_frame(input string name, input int max_gap);
    got_wr_q.delete();
    multi_cnt = 0;
    foreach (frame_q[i]) send_byte(frame_q[i], $urandom_range(0, max_gap));
    repeat (3) @(negedge clk);
    #1;
    check_val({name, "_nwr"}, 32'(got_wr_q.size()), 32'(exp_wr_q.size()));
    for (int i = 0; i < exp_wr_q.size() && i < got_wr_q.size(); i++)
      check_val({name, "_wr"}, 32'(got_wr_q[i]), 32'(exp_wr_q[i]));
    check_val({name, "_done"},   32'(bus.done),      32'(exp_done));
    check_val({name, "_error"},  32'(bus.error),     32'(exp_error));
    check_val({name, "_hold"},   32'(bus.core_hold), 32'(!exp_done));
    check_val({name, "_wcnt"},   32'(bus.word_cnt),  32'(exp_wcnt));
    check_val({name, "_strobe"}, 32'(multi_cnt),     32'(0));
    check_val({name, "_ready"},  32'(bus.in_ready),  32'(1));
    $display("frame %s: bytes=%0d writes=%0d done=%0b error=%0b word_cnt=%0d",
             name, frame_q.size(), got_wr_q.size(), bus.done, bus.error, bus.word_cnt);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    logic [7:0] garbage [3];
    int         n;
    garbage = '{8'h00, 8'hFF, 8'h5A};
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;

    repeat (3) @(negedge clk);
    check_val("rst_ready", 32'(bus.in_ready),         32'(0));
    check_val("rst_hold",  32'(bus.core_hold),        32'(1));
    check_val("rst_done",  32'(bus.done),             32'(0));
    check_val("rst_error", 32'(bus.error),            32'(0));
    check_val("rst_write", 32'(bus.IDATA_PROG_write), 32'(0));
    check_val("rst_addr",  32'(bus.IDATA_PROG_addr),  32'(0));
    check_val("rst_data",  32'(bus.IDATA_PROG_data),  32'(0));
    check_val("rst_wcnt",  32'(bus.word_cnt),         32'(0));
    rst = 1'b1;
    @(negedge clk);
    check_val("post_rst_ready", 32'(bus.in_ready),  32'(1));
    check_val("post_rst_hold",  32'(bus.core_hold), 32'(1));
    $display("reset: in_ready=%0b core_hold=%0b", bus.in_ready, bus.core_hold);

    word_q = '{16'h1234, 16'hABCD};
    build_frame(2, 1'b0);
    run_frame("good2", 0);
    build_frame(2, 1'b1);
    run_frame("badchk", 2);
    build_frame(DEPTH + 1, 1'b0);
    run_frame("oversize", 1);
    fill_random(3);
    build_frame(3, 1'b0);
    run_frame("recover", 2);

    fill_random(DEPTH);
    word_q[0] = 16'hA5A5;
    word_q[1] = 16'h00A5;
    build_frame(DEPTH, 1'b0);
    run_frame("full_depth", 1);

    got_wr_q.delete();
    send_byte(8'hA5, 0);
    send_byte(8'h00, 0);
    send_byte(8'h03, 0);
    repeat (TIMEOUT - 1) @(negedge clk);
    check_val("tmo_early", 32'(bus.error), 32'(0));
    @(negedge clk);
    #1;
    check_val("tmo_error", 32'(bus.error),       32'(1));
    check_val("tmo_done",  32'(bus.done),        32'(0));
    check_val("tmo_hold",  32'(bus.core_hold),   32'(1));
    check_val("tmo_nwr",   32'(got_wr_q.size()), 32'(0));
    $display("timeout: error=%0b after %0d idle cycles", bus.error, TIMEOUT);

    got_wr_q.delete();
    foreach (garbage[i]) send_byte(garbage[i], $urandom_range(0, 3));
    @(negedge clk);
    #1;
    check_val("garbage_nwr",   32'(got_wr_q.size()), 32'(0));
    check_val("garbage_error", 32'(bus.error),       32'(1));
    $display("garbage: discarded %0d bytes", 3);
    word_q.delete();
    build_frame(0, 1'b0);
    run_frame("empty", 3);

    for (int it = 0; it < 20; it++) begin
      n = ($urandom_range(0, 9) == 0) ? DEPTH + 1 + $urandom_range(0, 500)
                                      : $urandom_range(0, 12);
      if (n <= DEPTH) fill_random(n);
      build_frame(n, $urandom_range(0, 3) == 0);
      run_frame("rand", 3);
    end

    send_byte(8'hA5, 0);
    send_byte(8'h00, 0);
    send_byte(8'h04, 0);
    send_byte(8'h12, 1);
    send_byte(8'h34, 1);
    check_val("mid_write_pre", 32'(bus.IDATA_PROG_write), 32'(1));
    #2;
    rst = 1'b0;
    #1;
    check_val("mid_write", 32'(bus.IDATA_PROG_write), 32'(0));
    check_val("mid_ready", 32'(bus.in_ready),         32'(0));
    check_val("mid_hold",  32'(bus.core_hold),        32'(1));
    check_val("mid_done",  32'(bus.done),             32'(0));
    check_val("mid_error", 32'(bus.error),            32'(0));
    check_val("mid_wcnt",  32'(bus.word_cnt),         32'(0));
    check_val("mid_addr",  32'(bus.IDATA_PROG_addr),  32'(0));
    check_val("mid_data",  32'(bus.IDATA_PROG_data),  32'(0));
    $display("mid-frame reset: write=%0b data=0x%0h", bus.IDATA_PROG_write, bus.IDATA_PROG_data);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    fill_random(2);
    build_frame(2, 1'b0);
    run_frame("post_reset", 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
